// File: rtl/data_mem_responder.sv
// Data-memory responder: target side of the CPU load/store request interface.
// Accepts one request at a time, waits a fixed latency, performs the access
// on local 16-bit word storage and holds the response until it is consumed.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [14:0] waddr_q, waddr_d;      // byte address with bit 0 dropped
    logic [15:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [15:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic              access;
    logic              mem_we;
    logic              unused_addr_lsb;

    // Byte-address bit 0 has no meaning for word accesses.
    assign unused_addr_lsb = req_addr[0];

    assign word_idx     = waddr_q[ADDR_W-1:0];
    assign out_of_range = |waddr_q[14:ADDR_W];
    assign access       = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we       = access && wr_q && !out_of_range;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Next-state logic: accept, count down latency, respond, wait for consume.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    waddr_d = req_addr[15:1];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = out_of_range;
                    resp_rdata_d = (!wr_q && !out_of_range) ? mem_q[word_idx] : 16'h0000;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 16'h0000;
                    resp_err_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            waddr_q      <= 15'd0;
            wdata_q      <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'h0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Word storage; contents survive reset, writes only at the access edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table vectors, hand-written
// reset/throughput sequences and randomized traffic against a memory model.
module tb_data_mem_responder;

    localparam int LAT = 3;
    localparam int AW  = 10;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_rdata;

    logic        req_valid1, req_ready1, req_wr1;
    logic [15:0] req_addr1, req_wdata1;
    logic        resp_valid1, resp_ready1, resp_err1;
    logic [15:0] resp_rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] model_mem [int];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        bit          exp_err;
        int          hold;
    } vec_t;

    vec_t tbl [11];

    data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.ADDR_W(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [15:0] a);
        return (int'(a) >> (AW + 1)) != 0;
    endfunction

    function automatic int m_idx(input logic [15:0] a);
        return (int'(a) / 2) % (1 << AW);
    endfunction

    // Present a request at a negedge and return at the negedge after acceptance.
    task automatic send_req(input bit wr, input logic [15:0] a, input logic [15:0] wd);
        int w;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_wr = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    endtask

    task automatic xact(input string nm, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input int hold, input bit chk_rd,
                        input logic [15:0] exp_rd, input bit exp_err);
        int          lat;
        logic [15:0] rd;
        logic        er;
        send_req(wr, a, wd);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".latency"}, lat, LAT);
        rd = resp_rdata;
        er = resp_err;
        if (chk_rd) chk({nm, ".rdata"}, rd, exp_rd);
        chk({nm, ".err"}, er, exp_err);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_wr = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
            @(negedge clk);
            chk({nm, ".hold_valid"}, resp_valid, 1);
            chk({nm, ".hold_rdata"}, resp_rdata, rd);
            chk({nm, ".hold_err"}, resp_err, er);
            chk({nm, ".hold_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk({nm, ".rel_valid"}, resp_valid, 0);
        chk({nm, ".rel_rdata"}, resp_rdata, 0);
        chk({nm, ".rel_err"}, resp_err, 0);
        chk({nm, ".rel_ready"}, req_ready, 1);
        if (wr && !m_err(a)) model_mem[m_idx(a)] = wd;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h0040, 16'hBEEF, 16'h0000, 1'b0, 0};
        tbl[1]  = '{1'b0, 16'h0041, 16'h0000, 16'hBEEF, 1'b0, 0};
        tbl[2]  = '{1'b1, 16'h0010, 16'h5A5A, 16'h0000, 1'b0, 1};
        tbl[3]  = '{1'b1, 16'h0000, 16'h5555, 16'h0000, 1'b0, 0};
        tbl[4]  = '{1'b1, 16'h0800, 16'h1234, 16'h0000, 1'b1, 0};
        tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h5555, 1'b0, 0};
        tbl[6]  = '{1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b1, 0};
        tbl[7]  = '{1'b1, 16'h07FE, 16'h7777, 16'h0000, 1'b0, 0};
        tbl[8]  = '{1'b0, 16'h07FF, 16'h0000, 16'h7777, 1'b0, 2};
        tbl[9]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 1};
        tbl[10] = '{1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 5};

        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        resp_ready = 1'b0;
        req_valid1 = 1'b0; req_wr1 = 1'b0; req_addr1 = 16'h0; req_wdata1 = 16'h0;
        resp_ready1 = 1'b1;

        // Reset state and idle behaviour
        @(negedge clk);
        @(negedge clk);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.resp_rdata", resp_rdata, 0);
        chk("rst.resp_err", resp_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.req_ready", req_ready, 1);
            chk("idle.resp_valid", resp_valid, 0);
        end

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            xact($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                 tbl[i].hold, 1'b1, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Asynchronous reset while a response is pending
        send_req(1'b0, 16'h0041, 16'h0);
        for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
        chk("midrst.pre_valid", resp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.resp_valid", resp_valid, 0);
        chk("midrst.resp_rdata", resp_rdata, 0);
        chk("midrst.resp_err", resp_err, 0);
        chk("midrst.req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during WAIT abandons a store
        send_req(1'b1, 16'h0010, 16'hAAAA);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("waitrst.resp_valid", resp_valid, 0);
            chk("waitrst.req_ready", req_ready, 1);
        end
        xact("waitrst.load", 1'b0, 16'h0010, 16'h0, 0, 1'b1, 16'h5A5A, 1'b0);

        // Back-to-back throughput on the LATENCY=1 instance
        req_valid1 = 1'b1; req_wr1 = 1'b1; req_addr1 = 16'h0100; req_wdata1 = 16'h1111;
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("thru.ready%0d", n), req_ready1, (n % 3 == 0) ? 1 : 0);
            chk($sformatf("thru.valid%0d", n), resp_valid1, (n % 3 == 2) ? 1 : 0);
            if (resp_valid1) chk("thru.err", resp_err1, 0);
            @(negedge clk);
            req_addr1 = req_addr1 + 16'd2;
        end
        req_valid1 = 1'b0;

        // Randomized traffic against the memory model
        for (int k = 0; k < 40; k++) begin
            bit          wr;
            logic [15:0] a, wd, exp_rd;
            bit          er, crd;
            wr = 1'($urandom);
            wd = 16'($urandom);
            if ($urandom_range(0, 9) < 2)
                a = 16'({5'($urandom_range(1, 31)), 11'($urandom)});
            else
                a = 16'($urandom_range(0, 31) * 2 + $urandom_range(0, 1));
            er = m_err(a);
            crd = 1'b1;
            exp_rd = 16'h0000;
            if (!wr && !er) begin
                if (model_mem.exists(m_idx(a))) exp_rd = model_mem[m_idx(a)];
                else crd = 1'b0;
            end
            xact($sformatf("rnd%0d", k), wr, a, wd, int'($urandom_range(0, 3)), crd, exp_rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the target side of the CPU's load/store memory request interface.
- Accepts one word request at a time over a valid/ready handshake, models a fixed access latency, and returns the read data or write acknowledge over a second valid/ready handshake.
- Sits between the CPU datapath (ALU address, register-file store data) and on-chip 16-bit word storage.

Parameters:
- ADDR_W, 10, word-index width; storage depth = 2^ADDR_W 16-bit words.
- LATENCY, 3, cycles from request accept to resp_valid; legal range 1..15.

Ports:
- clk, input, 1, sole clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, initiator presents a request.
- req_ready, output, 1, responder can accept a request.
- req_wr, input, 1, 1 = store, 0 = load.
- req_addr, input, 16, byte address; bit 0 ignored (word-aligned access).
- req_wdata, input, 16, store data.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, initiator consumes the response.
- resp_rdata, output, 16, load data; 0 for stores and errors.
- resp_err, output, 1, address out of range.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0, latched request cleared.
  - req_ready=1 once in IDLE.
  - Storage contents are not reset.
  - Reset during WAIT or RESP abandons the request; a pending store is never committed.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE), driven combinationally from state only.
  - IDLE: on an edge with req_valid&&req_ready, latch req_wr, req_addr, req_wdata; load counter = LATENCY-1; go to WAIT. Request inputs are sampled only at accept and may change afterwards.
  - WAIT: counter decrements each cycle. On the edge where counter==0:
    - perform the access: store writes the array; load captures the array word into resp_rdata.
    - set resp_valid=1 and resp_err; go to RESP.
  - RESP: resp_valid, resp_rdata and resp_err hold stable until an edge with resp_ready=1. On that edge: resp_valid=0, resp_rdata=0, resp_err=0; go to IDLE.
  - resp_ready high early (before resp_valid) has no effect.
- Timing:
  - Accept at edge T → resp_valid high from edge T+LATENCY.
  - With resp_ready held high, the next request is accepted at edge T+LATENCY+2. Maximum throughput is one request per LATENCY+2 cycles.
- Addressing:
  - word index = req_addr[ADDR_W:1].
  - Out of range when req_addr[15:ADDR_W+1] != 0. In that case no array write occurs, resp_rdata=0, resp_err=1.
- Store response: resp_rdata=0, resp_err per range check.
- Ordering: strictly one outstanding request. A load following a store to the same word returns the stored value.
- No combinational path from any request input to any output.

Test Plan:
1. Reset then idle: rst_n low mid-cycle → resp_valid=0, resp_rdata=0, resp_err=0 immediately; after release req_ready=1, outputs hold with req_valid=0.
2. Store/load round trip (LATENCY=3): store 16'hBEEF @ 16'h0040, accepted at edge T → resp_valid at T+3, rdata=0, err=0. Then load @ 16'h0041 → resp_rdata=16'hBEEF, err=0 (bit 0 ignored).
3. Response backpressure: load completes; resp_ready held 0 for 5 cycles → resp_valid/rdata stable and req_ready=0 throughout; new req_valid is not accepted until one edge after resp_ready=1.
4. Out of range (ADDR_W=10): store 16'h1234 @ 16'h0800 → resp_err=1. Load @ 16'h0000 afterwards returns its prior value, confirming no aliasing write.
5. Reset mid-WAIT: store 16'hAAAA @ 16'h0010 accepted; assert rst_n low at cycle T+1 → no response. Later load @ 16'h0010 returns the pre-store value.
6. Throughput with LATENCY=1, resp_ready tied high, req_valid tied high: accepts at edges T, T+3, T+6; resp_valid high exactly one cycle per request.
